inst_encoder_loader: RTL and testbench
======================================

Name: inst_encoder_loader

Overview:
- Writer side of the instruction word format consumed by the instruction decoder.
- Accepts instruction fields over a valid/ready handshake and packs them into 32-bit words in R/I/J/S format.
- Writes the packed words sequentially into instruction memory through an acknowledged write port.
- Used by the test/boot path to load programs; flags illegal opcodes and out-of-segment jump targets.

Parameters:
- ADDR_W, 10, instruction memory word-address width.
- DEPTH, 1024, maximum instructions per load session (at most 2**ADDR_W).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a session at base_addr.
- base_addr  in  ADDR_W  first word address of the session.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle.
- opcode  in  6  instruction opcode.
- rd, rs1, rs2  in  4 each  register fields.
- imm16  in  16  I-type immediate.
- mode  in  2  I-type mode.
- j_target  in  32  absolute J-type target PC.
- mem_we  out  1  write request, held until mem_ack.
- mem_addr  out  ADDR_W  write word address.
- mem_wdata  out  32  packed instruction word.
- mem_ack  in  1  memory accepted the write this cycle.
- count  out  ADDR_W+1  words written this session.
- full  out  1  count == DEPTH.
- err_illegal  out  1  sticky: an illegal opcode was dropped.
- err_range  out  1  sticky: a J-target lies outside the current segment.

Behaviour:
- Reset: state IDLE; in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, count=0, full=0, err_illegal=0, err_range=0. Session disarmed.
- start in any state:
  - Aborts any pending write (mem_we drops next cycle).
  - Loads mem_addr=base_addr; clears count and both error flags.
  - Arms the session and goes to IDLE.
- IDLE: in_ready = armed && !full. A transfer occurs on in_valid && in_ready.
- On transfer, classify p=opcode[5:2]:
  - R: p==0000 and opcode!=000011. Word = {opcode, rd, rs1, rs2, 14'b0}.
  - I: p==0001, p==0010, or opcode==000011. Word = {opcode, rd, rs1, imm16, mode}.
  - J: opcode 001100 (JMP) or 001101 (CALL). Word = {opcode, j_target[25:0]}.
    - If j_target[31:26] != slot PC[31:26], where slot PC = zero-extended mem_addr, set err_range. The word is still written.
  - S: opcode 001111 (PUSH) or 010000 (POP). Word = {opcode, rd, 22'b0}.
  - Any other opcode is illegal: set err_illegal, write nothing, stay in IDLE. in_ready stays high, so back-to-back bundles are accepted.
- Legal word: registered into mem_wdata; next state WRITE. Latency: mem_we asserts the cycle after the transfer.
- WRITE:
  - in_ready=0; mem_we=1; mem_addr and mem_wdata held stable until mem_ack.
  - On mem_ack: mem_addr+1 (wraps modulo 2**ADDR_W), count+1, return to IDLE.
  - Next acceptance is possible the cycle after ack, so throughput is 1 word per 2 cycles with immediate ack.
- full: asserted when count reaches DEPTH. in_ready stays 0 until the next start.
- Asynchronous reset mid-WRITE: mem_we drops immediately and the partial write is abandoned.
- start and in_valid in the same cycle: start wins and the bundle is not accepted.
- mem_ack outside WRITE is ignored.

Test Plan:
- Reset, start with base_addr=0x010, then R bundle opcode=000001, rd=3, rs1=4, rs2=5, immediate ack -> mem_we at 0x010, wdata=0x04D14000, count=1.
- I bundle opcode=000011, rd=1, rs1=2, imm16=0xFFFF, mode=2; ack delayed 3 cycles -> wdata=0x0C4BFFFE held 3 cycles with in_ready=0, then mem_addr=0x011.
- J opcode=001100, target=0x000000AB at slot 0x012 -> wdata=0x300000AB, err_range=0. Then target=0x040000AB -> word written, err_range=1.
- Illegal opcode=111111 -> no mem_we, err_illegal=1, count unchanged; a following S PUSH rd=7 writes 0x3DC00000.
- DEPTH=4: write 4 words -> full=1, in_ready=0. start -> count=0, errors cleared, in_ready=1.
- rst_n low during WRITE -> mem_we=0 in the same cycle; all outputs at reset values.

Source files
------------

// File: rtl/inst_encoder_loader.sv
// ============================================================================
//  Module   : inst_encoder_loader
//  Function : Packs instruction field bundles into R/I/J/S words and writes
//             them sequentially into instruction memory over an acked port.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module inst_encoder_loader #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        opcode,
    input  logic [3:0]        rd,
    input  logic [3:0]        rs1,
    input  logic [3:0]        rs2,
    input  logic [15:0]       imm16,
    input  logic [1:0]        mode,
    input  logic [31:0]       j_target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err_illegal,
    output logic              err_range
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    localparam logic [5:0]        c_op_i3    = 6'b000011;
    localparam logic [5:0]        c_op_jmp   = 6'b001100;
    localparam logic [5:0]        c_op_call  = 6'b001101;
    localparam logic [5:0]        c_op_push  = 6'b001111;
    localparam logic [5:0]        c_op_pop   = 6'b010000;
    localparam logic [31:0]       c_seg_mask = 32'hFC00_0000;
    localparam logic [ADDR_W:0]   c_depth    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_cnt_one  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] c_addr_one = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_armed;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [ADDR_W:0]   r_count;
    logic              r_err_illegal;
    logic              r_err_range;

    logic [3:0]        w_p;
    logic              w_is_r;
    logic              w_is_i;
    logic              w_is_j;
    logic              w_is_s;
    logic              w_legal;
    logic [31:0]       w_word;
    logic [31:0]       w_slot_pc;
    logic              w_range_bad;
    logic              w_full;
    logic              w_in_ready;
    logic              w_fire;

    assign w_p         = opcode[5:2];
    assign w_full      = (r_count == c_depth);
    assign w_in_ready  = (r_state == IDLE) && r_armed && !w_full;
    // start has priority over a bundle presented in the same cycle
    assign w_fire      = in_valid && w_in_ready && !start;
    assign w_slot_pc   = 32'(r_addr);
    assign w_range_bad = |((j_target ^ w_slot_pc) & c_seg_mask);

    always_comb begin
        w_is_r = (w_p == 4'd0) && (opcode != c_op_i3);
        w_is_i = (w_p == 4'd1) || (w_p == 4'd2) || (opcode == c_op_i3);
        w_is_j = (opcode == c_op_jmp) || (opcode == c_op_call);
        w_is_s = (opcode == c_op_push) || (opcode == c_op_pop);
        w_legal = w_is_r || w_is_i || w_is_j || w_is_s;
        w_word = 32'd0;
        if (w_is_r) begin
            w_word = {opcode, rd, rs1, rs2, 14'd0};
        end else if (w_is_i) begin
            w_word = {opcode, rd, rs1, imm16, mode};
        end else if (w_is_j) begin
            w_word = {opcode, j_target[25:0]};
        end else if (w_is_s) begin
            w_word = {opcode, rd, 22'd0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (start) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_fire && w_legal) w_state_nxt = WRITE;
                WRITE:   if (mem_ack) w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed       <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_count       <= '0;
            r_err_illegal <= 1'b0;
            r_err_range   <= 1'b0;
        end else if (start) begin
            r_armed       <= 1'b1;
            r_addr        <= base_addr;
            r_count       <= '0;
            r_err_illegal <= 1'b0;
            r_err_range   <= 1'b0;
        end else begin
            if (w_fire) begin
                if (!w_legal) begin
                    r_err_illegal <= 1'b1;
                end else begin
                    r_wdata <= w_word;
                    if (w_is_j && w_range_bad) begin
                        r_err_range <= 1'b1;
                    end
                end
            end
            if ((r_state == WRITE) && mem_ack) begin
                r_addr  <= r_addr + c_addr_one;
                r_count <= r_count + c_cnt_one;
            end
        end
    end

    assign in_ready    = w_in_ready;
    assign mem_we      = (r_state == WRITE);
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign count       = r_count;
    assign full        = w_full;
    assign err_illegal = r_err_illegal;
    assign err_range   = r_err_range;

endmodule

`default_nettype wire

// File: tb/tb_inst_encoder_loader.sv
// ============================================================================
//  Module   : tb_inst_encoder_loader
//  Function : Self-checking bench for inst_encoder_loader (DEPTH=4 instance).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_inst_encoder_loader;

    localparam int AW = 10;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [5:0]    opcode = '0;
    logic [3:0]    rd = '0, rs1 = '0, rs2 = '0;
    logic [15:0]   imm16 = '0;
    logic [1:0]    mode = '0;
    logic [31:0]   j_target = '0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ack = 1'b0;
    logic [AW:0]   count;
    logic          full, err_illegal, err_range;

    inst_encoder_loader #(.ADDR_W(AW), .DEPTH(DP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode), .rd(rd),
        .rs1(rs1), .rs2(rs2), .imm16(imm16), .mode(mode), .j_target(j_target),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .count(count), .full(full),
        .err_illegal(err_illegal), .err_range(err_range)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // memory responder: acks after ack_delay idle cycles of a held request
    typedef struct packed { logic [AW-1:0] a; logic [31:0] d; } wr_t;
    wr_t written[$];
    int  ack_delay = 0;
    int  wait_cnt  = 0;

    always @(negedge clk) begin
        if (!rst_n || !mem_we) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (wait_cnt >= ack_delay) begin
            mem_ack = 1'b1;
            written.push_back({mem_addr, mem_wdata});
        end else begin
            wait_cnt++;
        end
    end

    // reference model of the session
    logic [AW-1:0] m_addr;
    int            m_count;
    bit            m_ill, m_rng;

    function automatic bit ref_word(input int op, input int frd, input int frs1, input int frs2,
                                    input int fimm, input int fmd, input logic [31:0] jt,
                                    output logic [31:0] w, output bit is_j);
        int p = op / 4;
        is_j = 1'b0;
        w    = 32'd0;
        if (p == 0 && op != 3)                w = (32'(op) << 26) | (32'(frd) << 22) | (32'(frs1) << 18) | (32'(frs2) << 14);
        else if (p == 1 || p == 2 || op == 3) w = (32'(op) << 26) | (32'(frd) << 22) | (32'(frs1) << 18) | (32'(fimm) << 2) | 32'(fmd);
        else if (op == 12 || op == 13)        begin w = (32'(op) << 26) | (jt % 32'h0400_0000); is_j = 1'b1; end
        else if (op == 15 || op == 16)        w = (32'(op) << 26) | (32'(frd) << 22);
        else return 1'b0;
        return 1'b1;
    endfunction

    task automatic pulse_start(input logic [AW-1:0] a);
        @(negedge clk);
        start = 1'b1; base_addr = a;
        @(negedge clk);
        start = 1'b0;
        m_addr = a; m_count = 0; m_ill = 1'b0; m_rng = 1'b0;
    endtask

    task automatic send(input int op, input int frd, input int frs1, input int frs2, input int fimm,
                        input int fmd, input logic [31:0] jt, output bit ok);
        @(negedge clk);
        opcode = 6'(op); rd = 4'(frd); rs1 = 4'(frs1); rs2 = 4'(frs2);
        imm16 = 16'(fimm); mode = 2'(fmd); j_target = jt; in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_write(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (written.size() > 0) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, count, full, err_illegal, err_range} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b we=%b addr=%h wd=%h cnt=%0d full=%b ei=%b er=%b required all zero",
                     in_ready, mem_we, mem_addr, mem_wdata, count, full, err_illegal, err_range);
        end
        rst_n = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; opcode = 6'd1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || mem_we !== 1'b0) begin
            errors++; $display("FAIL disarmed got rdy=%b we=%b required 0 0", in_ready, mem_we);
        end
    endtask

    task automatic test_r_type();
        bit ok, okw;
        wr_t rec;
        pulse_start(10'h010);
        checks++;
        if (in_ready !== 1'b1 || count !== 0) begin
            errors++; $display("FAIL start_arm got rdy=%b cnt=%0d required 1 0", in_ready, count);
        end
        send(1, 3, 4, 5, 0, 0, 32'd0, ok);
        checks++;
        if (!ok || mem_we !== 1'b1 || mem_addr !== 10'h010 || mem_wdata !== 32'h04D1_4000) begin
            errors++; $display("FAIL r_word got we=%b addr=%h wd=%h required 1 010 04d14000", mem_we, mem_addr, mem_wdata);
        end
        wait_write(okw);
        rec = okw ? written.pop_front() : '0;
        checks++;
        if (!okw || rec !== {10'h010, 32'h04D1_4000} || count !== 1) begin
            errors++; $display("FAIL r_commit got rec=%h cnt=%0d required %h 1", rec, count, {10'h010, 32'h04D1_4000});
        end
    endtask

    task automatic test_i_delayed_ack();
        bit ok, okw;
        wr_t rec;
        ack_delay = 3;
        send(3, 1, 2, 0, 16'hFFFF, 2, 32'd0, ok);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (!ok || mem_we !== 1'b1 || in_ready !== 1'b0 || mem_wdata !== 32'h0C4B_FFFE ||
                mem_addr !== 10'h011 || written.size() != 0) begin
                errors++; $display("FAIL i_hold[%0d] got we=%b rdy=%b wd=%h addr=%h required 1 0 0c4bfffe 011",
                                   k, mem_we, in_ready, mem_wdata, mem_addr);
            end
            @(negedge clk);
        end
        wait_write(okw);
        rec = okw ? written.pop_front() : '0;
        checks++;
        if (!okw || rec !== {10'h011, 32'h0C4B_FFFE} || mem_addr !== 10'h012 || count !== 2) begin
            errors++; $display("FAIL i_commit got rec=%h addr=%h cnt=%0d required addr 012 cnt 2", rec, mem_addr, count);
        end
        ack_delay = 0;
    endtask

    task automatic test_jump_range();
        bit ok, okw;
        wr_t rec;
        send(12, 0, 0, 0, 0, 0, 32'h0000_00AB, ok);
        wait_write(okw);
        rec = okw ? written.pop_front() : '0;
        checks++;
        if (!ok || !okw || rec !== {10'h012, 32'h3000_00AB} || err_range !== 1'b0) begin
            errors++; $display("FAIL j_in_seg got rec=%h er=%b required %h 0", rec, err_range, {10'h012, 32'h3000_00AB});
        end
        send(12, 0, 0, 0, 0, 0, 32'h0400_00AB, ok);
        wait_write(okw);
        rec = okw ? written.pop_front() : '0;
        checks++;
        if (!ok || !okw || rec !== {10'h013, 32'h3000_00AB} || err_range !== 1'b1) begin
            errors++; $display("FAIL j_out_seg got rec=%h er=%b required %h 1", rec, err_range, {10'h013, 32'h3000_00AB});
        end
        checks++;
        if (count !== 4 || full !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL full got cnt=%0d full=%b rdy=%b required 4 1 0", count, full, in_ready);
        end
    endtask

    task automatic test_illegal_push_wrap();
        bit ok, okw;
        wr_t rec;
        pulse_start(10'h3FE);
        checks++;
        if (count !== 0 || full !== 1'b0 || err_illegal !== 1'b0 || err_range !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL restart got cnt=%0d full=%b ei=%b er=%b rdy=%b required 0 0 0 0 1",
                               count, full, err_illegal, err_range, in_ready);
        end
        send(63, 1, 1, 1, 0, 0, 32'd0, ok);
        repeat (2) @(negedge clk);
        checks++;
        if (!ok || mem_we !== 1'b0 || err_illegal !== 1'b1 || in_ready !== 1'b1 || count !== 0 || written.size() != 0) begin
            errors++; $display("FAIL illegal got we=%b ei=%b rdy=%b cnt=%0d required 0 1 1 0", mem_we, err_illegal, in_ready, count);
        end
        send(15, 7, 0, 0, 0, 0, 32'd0, ok);
        wait_write(okw);
        rec = okw ? written.pop_front() : '0;
        checks++;
        if (!ok || !okw || rec !== {10'h3FE, 32'h3DC0_0000}) begin
            errors++; $display("FAIL push got rec=%h required %h", rec, {10'h3FE, 32'h3DC0_0000});
        end
        send(16, 2, 0, 0, 0, 0, 32'd0, ok);
        wait_write(okw);
        rec = okw ? written.pop_front() : '0;
        checks++;
        if (!ok || !okw || rec !== {10'h3FF, 32'h4080_0000} || mem_addr !== 10'h000 || count !== 2) begin
            errors++; $display("FAIL pop_wrap got rec=%h addr=%h cnt=%0d required %h 000 2", rec, mem_addr, count, {10'h3FF, 32'h4080_0000});
        end
    endtask

    task automatic test_start_priority();
        @(negedge clk);
        start = 1'b1; base_addr = 10'h100; in_valid = 1'b1; opcode = 6'd1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
        checks++;
        if (mem_we !== 1'b0 || count !== 0 || mem_addr !== 10'h100 || err_illegal !== 1'b0) begin
            errors++; $display("FAIL start_wins got we=%b cnt=%0d addr=%h ei=%b required 0 0 100 0", mem_we, count, mem_addr, err_illegal);
        end
    endtask

    task automatic test_abort();
        bit ok;
        ack_delay = 10;
        send(4, 1, 1, 0, 5, 1, 32'd0, ok);
        checks++;
        if (!ok || mem_we !== 1'b1) begin
            errors++; $display("FAIL abort_setup got we=%b required 1", mem_we);
        end
        start = 1'b1; base_addr = 10'h200;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== 10'h200 || count !== 0 || in_ready !== 1'b1 || written.size() != 0) begin
            errors++; $display("FAIL abort got we=%b addr=%h cnt=%0d rdy=%b required 0 200 0 1", mem_we, mem_addr, count, in_ready);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        send(8, 2, 3, 0, 7, 0, 32'd0, ok);
        checks++;
        if (!ok || mem_we !== 1'b1) begin
            errors++; $display("FAIL areset_setup got we=%b required 1", mem_we);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, count, full, err_illegal, err_range} !== '0) begin
            errors++; $display("FAIL async_reset got rdy=%b we=%b addr=%h wd=%h cnt=%0d required all zero",
                               in_ready, mem_we, mem_addr, mem_wdata, count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ack_delay = 0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || written.size() != 0) begin
            errors++; $display("FAIL post_reset got rdy=%b writes=%0d required 0 0", in_ready, written.size());
        end
    endtask

    task automatic test_random();
        int legal_ops[10] = '{0, 1, 2, 3, 5, 9, 12, 13, 15, 16};
        int op, frd, frs1, frs2, fimm, fmd;
        logic [31:0] jt, w;
        bit legal, is_j, ok, okw;
        wr_t rec;
        written.delete();
        pulse_start(AW'($urandom));
        for (int n = 0; n < 60; n++) begin
            if (m_count == DP) begin
                checks++;
                if (full !== 1'b1 || in_ready !== 1'b0) begin
                    errors++; $display("FAIL rnd_full[%0d] got full=%b rdy=%b required 1 0", n, full, in_ready);
                end
                pulse_start(AW'($urandom));
            end
            op   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 63)) : legal_ops[$urandom_range(0, 9)];
            frd  = $urandom_range(0, 15); frs1 = $urandom_range(0, 15); frs2 = $urandom_range(0, 15);
            fimm = $urandom_range(0, 65535); fmd = $urandom_range(0, 3);
            jt   = $urandom;
            if ($urandom_range(0, 1) == 1) jt = jt % 32'h0400_0000;
            ack_delay = $urandom_range(0, 2);
            legal = ref_word(op, frd, frs1, frs2, fimm, fmd, jt, w, is_j);
            send(op, frd, frs1, frs2, fimm, fmd, jt, ok);
            if (legal) begin
                wait_write(okw);
                rec = okw ? written.pop_front() : '0;
                checks++;
                if (!ok || !okw || rec !== {m_addr, w}) begin
                    errors++; $display("FAIL rnd_write[%0d] op=%0d got rec=%h required %h", n, op, rec, {m_addr, w});
                end
                if (is_j && ((jt >> 26) != (32'(m_addr) >> 26))) m_rng = 1'b1;
                m_addr  = m_addr + 1'b1;
                m_count = m_count + 1;
            end else begin
                m_ill = 1'b1;
                checks++;
                if (!ok || mem_we !== 1'b0) begin
                    errors++; $display("FAIL rnd_drop[%0d] op=%0d got we=%b required 0", n, op, mem_we);
                end
            end
            checks++;
            if (count !== (AW+1)'(m_count) || err_illegal !== m_ill || err_range !== m_rng || mem_addr !== m_addr) begin
                errors++; $display("FAIL rnd_state[%0d] got cnt=%0d ei=%b er=%b addr=%h required %0d %b %b %h",
                                   n, count, err_illegal, err_range, mem_addr, m_count, m_ill, m_rng, m_addr);
            end
        end
        ack_delay = 0;
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_i_delayed_ack();
        test_jump_range();
        test_illegal_push_wrap();
        test_start_priority();
        test_abort();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
